// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, device-clocked shifting of
// data/parity/stop, acknowledge check and per-event timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             bit_q, bit_d;
    logic [9:0]       frame_q, frame_d;
    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             clk_prev_q, clk_prev_d;

    logic clk_s, data_s, fall, timeout;

    assign clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    assign data_sync_d = {data_sync_q[0], ps2_data_in};
    assign clk_s       = clk_sync_q[1];
    assign data_s      = data_sync_q[1];
    assign clk_prev_d  = clk_s;
    assign fall        = clk_prev_q & ~clk_s;
    assign timeout     = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Outputs decode straight from the state so an async reset releases the pins at once.
    assign tx_ready    = (state_q == IDLE);
    assign tx_busy     = (state_q != IDLE);
    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == REQUEST);
    assign ps2_data_oe = (state_q == REQUEST) || ((state_q == SEND) && !bit_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        tx_done = 1'b0;
        tx_err  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_valid) begin
                    // Frame shifts out LSB first: data, odd parity, stop.
                    frame_d = {1'b1, ~^tx_data, tx_data};
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = REQUEST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQUEST: begin
                cnt_d   = '0;
                idx_d   = '0;
                bit_d   = 1'b0;
                state_d = SEND;
            end
            SEND: begin
                if (timeout) begin
                    tx_err  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (fall) begin
                    cnt_d   = '0;
                    bit_d   = frame_q[0];
                    frame_d = {1'b1, frame_q[9:1]};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        state_d = ACK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (timeout) begin
                    tx_err  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                    if (!data_s) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        tx_err  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (timeout) begin
                    tx_err  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (clk_s && data_s) begin
                    tx_done = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (fall) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Synchronizers reset to the idle-high line level so reset release cannot fake a fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            bit_q       <= 1'b1;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            bit_q       <= bit_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector PS/2 device model clocks frames out
// of the host and checks them against a frame model built from the byte.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 300;
    localparam int H   = 6;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       dev_clk;
    logic       dev_data;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    // Wired-AND pins: either side may pull low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (tx_done) done_cnt++;
            if (tx_err) err_cnt++;
            if (tx_done && tx_err) both_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       ack_ok;
        logic [9:0] exp_frame;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame as the device sees it on its rising edges: 8 data LSB first, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = ((ones % 2) == 0);
        return {1'b1, p, d};
    endfunction

    task automatic start_req(input logic [7:0] d, input string tag);
        int w;
        w = 0;
        while (!tx_ready && w < 200) begin step(); w++; end
        if (!tx_ready) check({tag, " ready before request"}, 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic check_inhibit(input string tag);
        int   w;
        logic first_doe, last_doe;
        w = 0;
        first_doe = ps2_data_oe;
        last_doe  = 1'b0;
        check({tag, " clk_oe after handshake"}, 32'(ps2_clk_oe), 32'd1);
        check({tag, " busy after handshake"}, 32'(tx_busy), 32'd1);
        check({tag, " data released during inhibit"}, 32'(first_doe), 32'd0);
        while (ps2_clk_oe === 1'b1 && w < INH + 50) begin
            last_doe = ps2_data_oe;
            w++;
            step();
        end
        check({tag, " inhibit width"}, 32'(w), 32'(INH + 1));
        check({tag, " start bit before release"}, 32'(last_doe), 32'd1);
        check({tag, " start bit held"}, 32'(ps2_data_oe), 32'd1);
    endtask

    task automatic device_bits(input int n, inout logic [9:0] got);
        for (int i = 0; i < n; i++) begin
            repeat (H) step();
            dev_clk = 1'b0;
            repeat (H) step();
            dev_clk = 1'b1;
            got[i] = ps2_data_in;
        end
    endtask

    task automatic device_ack(input logic ack_ok);
        repeat (2) step();
        dev_data = ~ack_ok;
        repeat (H - 2) step();
        dev_clk = 1'b0;
        repeat (H) step();
        dev_clk = 1'b1;
        repeat (H) step();
        dev_data = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        while (!tx_ready && w < 100) begin step(); w++; end
        if (!tx_ready) check({tag, " ready returns"}, 32'(tx_ready), 32'd1);
    endtask

    task automatic do_xfer(input vec_t v, input string tag);
        logic [9:0] got;
        int d0, e0;
        got = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(v.data, tag);
        check_inhibit(tag);
        device_bits(10, got);
        device_ack(v.ack_ok);
        wait_ready(tag);
        check({tag, " frame"}, 32'(got), 32'(v.exp_frame));
        check({tag, " done pulses"}, 32'(done_cnt - d0), 32'(v.ack_ok ? 1 : 0));
        check({tag, " err pulses"}, 32'(err_cnt - e0), 32'(v.ack_ok ? 0 : 1));
    endtask

    initial begin
        vec_t       vecs[4];
        vec_t       rv;
        logic [9:0] got;
        int         t, d0, e0;

        vecs[0] = '{8'hED, 1'b1, 10'h3ED};
        vecs[1] = '{8'h07, 1'b1, 10'h207};
        vecs[2] = '{8'h00, 1'b1, 10'h300};
        vecs[3] = '{8'hA5, 1'b0, 10'h3A5};

        reset    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) step();
        check("reset clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset data_oe", 32'(ps2_data_oe), 32'd0);
        check("reset busy", 32'(tx_busy), 32'd0);
        check("reset done", 32'(tx_done), 32'd0);
        check("reset err", 32'(tx_err), 32'd0);
        check("reset ready", 32'(tx_ready), 32'd1);
        reset = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 4; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            rv.data      = 8'($urandom_range(0, 255));
            rv.ack_ok    = ($urandom_range(0, 3) != 0);
            rv.exp_frame = ref_frame(rv.data);
            do_xfer(rv, $sformatf("rand%0d", i));
        end

        // Device never clocks: timeout counted from the first released-clock cycle.
        e0 = err_cnt;
        d0 = done_cnt;
        start_req(8'h55, "tmo");
        check_inhibit("tmo");
        t = 0;
        while (!tx_err && t < TMO + 50) begin step(); t++; end
        check("tmo cycles to err", 32'(t), 32'(TMO));
        check("tmo no done with err", 32'(tx_done), 32'd0);
        step();
        check("tmo clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("tmo data_oe", 32'(ps2_data_oe), 32'd0);
        check("tmo ready", 32'(tx_ready), 32'd1);
        check("tmo err pulses", 32'(err_cnt - e0), 32'd1);
        check("tmo done pulses", 32'(done_cnt - d0), 32'd0);

        // Request held while busy: only accepted once ready returns.
        got = '0;
        d0 = done_cnt;
        start_req(8'hEE, "busy");
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        check_inhibit("busy");
        device_bits(10, got);
        device_ack(1'b1);
        wait_ready("busy");
        check("busy first frame", 32'(got), 32'(ref_frame(8'hEE)));
        check("busy first done", 32'(done_cnt - d0), 32'd1);
        step();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check_inhibit("busy2");
        got = '0;
        device_bits(10, got);
        device_ack(1'b1);
        wait_ready("busy2");
        check("busy second frame", 32'(got), 32'(ref_frame(8'hFF)));
        check("busy second done", 32'(done_cnt - d0), 32'd2);

        // Reset mid-frame while the host is driving a 0 bit.
        got = '0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_req(8'hF4, "rst");
        check_inhibit("rst");
        device_bits(4, got);
        check("rst bits so far", 32'(got[3:0]), 32'h4);
        check("rst data_oe before", 32'(ps2_data_oe), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst async clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst async data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst async busy", 32'(tx_busy), 32'd0);
        repeat (3) step();
        reset = 1'b1;
        check("rst no done", 32'(done_cnt - d0), 32'd0);
        check("rst no err", 32'(err_cnt - e0), 32'd0);
        repeat (2) step();
        rv.data      = 8'hF4;
        rv.ack_ok    = 1'b1;
        rv.exp_frame = 10'h2F4;
        do_xfer(rv, "after_rst");

        check("done and err never together", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
